// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller: state codes,
// opcode/funct constants, instruction classes and datapath mux selects.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE_ALU,
    C_ORI,
    C_LW,
    C_SW,
    C_BEQ,
    C_LUI,
    C_J,
    C_JAL,
    C_JR,
    C_ILLEGAL
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_JUMP = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;

  localparam logic [1:0] A3_RD    = 2'd0;
  localparam logic [1:0] A3_RT    = 2'd1;
  localparam logic [1:0] A3_RA    = 2'd2;

  localparam logic [1:0] REG_ALU  = 2'd0;
  localparam logic [1:0] REG_LUI  = 2'd1;
  localparam logic [1:0] REG_PC4  = 2'd2;

  localparam logic [1:0] ALUB_RT    = 2'd0;
  localparam logic [1:0] ALUB_IMM   = 2'd1;
  localparam logic [1:0] ALUB_SHAMT = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;

endpackage

// File: rtl/mc_decode.sv
// Combinational classifier: opcode/funct to instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLL: iclass = C_RTYPE_ALU;
          FN_JR:                    iclass = C_JR;
          default:                  iclass = C_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = C_ORI;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_LUI:  iclass = C_LUI;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath selects and write enables combinationally from the state.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [2:0] npc_op,
  output logic       zero_ext,
  output logic [1:0] a3_op,
  output logic [1:0] reg_op,
  output logic       reg_or_mem,
  output logic [1:0] alu_b_op,
  output logic [3:0] alu_op,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal
);

  state_e       state_q;
  state_e       state_d;
  instr_class_e iclass;

  // Taken/not-taken for beq is resolved inside the NPC; the controller only
  // selects the branch target path, so the flag is not consumed here.
  logic unused_zero;
  assign unused_zero = alu_zero;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    npc_op     = NPC_PC4;
    zero_ext   = 1'b0;
    a3_op      = A3_RD;
    reg_op     = REG_ALU;
    reg_or_mem = 1'b0;
    alu_b_op   = ALUB_RT;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;

    // ALU selects are held from EXEC through the last step of the instruction
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (iclass)
        C_RTYPE_ALU: begin
          if (funct == FN_SUBU) alu_op = ALU_SUB;
          else if (funct == FN_SLL) begin
            alu_op   = ALU_SLL;
            alu_b_op = ALUB_SHAMT;
          end
        end
        C_ORI: begin
          alu_op   = ALU_OR;
          alu_b_op = ALUB_IMM;
          zero_ext = 1'b1;
        end
        C_LW, C_SW: alu_b_op = ALUB_IMM;
        C_BEQ:      alu_op   = ALU_SUB;
        default: ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (iclass)
          C_J: begin
            pc_write   = 1'b1;
            npc_op     = NPC_JUMP;
            instr_done = 1'b1;
          end
          C_JAL: begin
            reg_write  = 1'b1;
            a3_op      = A3_RA;
            reg_op     = REG_PC4;
            pc_write   = 1'b1;
            npc_op     = NPC_JUMP;
            instr_done = 1'b1;
          end
          C_JR: begin
            pc_write   = 1'b1;
            npc_op     = NPC_JR;
            instr_done = 1'b1;
          end
          C_LUI: begin
            reg_write  = 1'b1;
            a3_op      = A3_RT;
            reg_op     = REG_LUI;
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
          C_ILLEGAL: begin
            illegal    = 1'b1;
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (iclass)
          C_BEQ: begin
            pc_write   = 1'b1;
            npc_op     = NPC_BEQ;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          C_LW, C_SW:         state_d = S_MEM;
          C_RTYPE_ALU, C_ORI: state_d = S_WB;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (iclass == C_SW) begin
          mem_write  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (iclass == C_LW) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (iclass == C_RTYPE_ALU || iclass == C_ORI || iclass == C_LW) begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          a3_op      = (iclass == C_RTYPE_ALU) ? A3_RD : A3_RT;
          reg_or_mem = (iclass == C_LW);
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every write and parks the selects at zero
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      npc_op     = NPC_PC4;
      zero_ext   = 1'b0;
      a3_op      = A3_RD;
      reg_op     = REG_ALU;
      reg_or_mem = 1'b0;
      alu_b_op   = ALUB_RT;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: every cycle of each instruction is compared
// against a hand-built vector of all outputs.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       pc_write, ir_write, reg_write, mem_write;
  logic [2:0] npc_op;
  logic       zero_ext;
  logic [1:0] a3_op, reg_op;
  logic       reg_or_mem;
  logic [1:0] alu_b_op;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic       instr_done, illegal;

  int n_assert = 0;
  int n_fail   = 0;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .npc_op     (npc_op),
    .zero_ext   (zero_ext),
    .a3_op      (a3_op),
    .reg_op     (reg_op),
    .reg_or_mem (reg_or_mem),
    .alu_b_op   (alu_b_op),
    .alu_op     (alu_op),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] obs;
  assign obs = {state, pc_write, ir_write, reg_write, mem_write, npc_op,
                zero_ext, a3_op, reg_op, reg_or_mem, alu_b_op, alu_op,
                instr_done, illegal};

  // Argument order mirrors the obs concatenation above.
  function automatic logic [23:0] v(input int st, input int pcw, input int irw,
                                    input int rw, input int mw, input int npc,
                                    input int zx, input int a3, input int rop,
                                    input int rom, input int bop, input int aop,
                                    input int done, input int ill);
    v = {st[2:0], pcw[0], irw[0], rw[0], mw[0], npc[2:0], zx[0], a3[1:0],
         rop[1:0], rom[0], bop[1:0], aop[3:0], done[0], ill[0]};
  endfunction

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [23:0] exp);
    @(negedge clk);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    opcode   = 6'b000000;
    funct    = 6'b000000;
    alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset_idle", v(0,0,0,0,0,0,0,0,0,0,0,0,0,0));

    // addu
    reset = 1'b0; opcode = 6'b000000; funct = 6'b100001;
    step("addu_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("addu_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("addu_exec",   v(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("addu_wb",     v(4,1,0,1,0,0,0,0,0,0,0,0,1,0));

    // lw
    opcode = 6'b100011; funct = 6'b000101;
    step("lw_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("lw_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("lw_exec",   v(2,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("lw_mem",    v(3,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("lw_wb",     v(4,1,0,1,0,0,0,1,0,1,1,0,1,0));

    // beq, taken then not taken: controller outputs are identical
    opcode = 6'b000100; funct = 6'b000000; alu_zero = 1'b1;
    step("beq1_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("beq1_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("beq1_exec",   v(2,1,0,0,0,1,0,0,0,0,0,1,1,0));
    alu_zero = 1'b0;
    step("beq0_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("beq0_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("beq0_exec",   v(2,1,0,0,0,1,0,0,0,0,0,1,1,0));

    // jal then jr
    opcode = 6'b000011; funct = 6'b000000;
    step("jal_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("jal_decode", v(1,1,0,1,0,2,0,2,2,0,0,0,1,0));
    opcode = 6'b000000; funct = 6'b001000;
    step("jr_fetch",   v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("jr_decode",  v(1,1,0,0,0,3,0,0,0,0,0,0,1,0));

    // unsupported opcode
    opcode = 6'b111111; funct = 6'b000000;
    step("ill_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("ill_decode", v(1,1,0,0,0,0,0,0,0,0,0,0,1,1));

    // sw interrupted by reset in MEM
    opcode = 6'b101011; funct = 6'b000000;
    step("sw_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("sw_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("sw_exec",   v(2,0,0,0,0,0,0,0,0,0,1,0,0,0));
    reset = 1'b1;
    step("sw_mem_rst", v(3,0,0,0,0,0,0,0,0,0,0,0,0,0));

    // ori restarts cleanly from FETCH
    reset = 1'b0; opcode = 6'b001101; funct = 6'b010101;
    step("ori_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("ori_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("ori_exec",   v(2,0,0,0,0,0,1,0,0,0,1,2,0,0));
    step("ori_wb",     v(4,1,0,1,0,0,1,1,0,0,1,2,1,0));

    // sll nop and subu
    opcode = 6'b000000; funct = 6'b000000;
    step("sll_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("sll_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("sll_exec",   v(2,0,0,0,0,0,0,0,0,0,2,3,0,0));
    step("sll_wb",     v(4,1,0,1,0,0,0,0,0,0,2,3,1,0));
    funct = 6'b100011;
    step("subu_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("subu_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("subu_exec",   v(2,0,0,0,0,0,0,0,0,0,0,1,0,0));
    step("subu_wb",     v(4,1,0,1,0,0,0,0,0,0,0,1,1,0));

    // lui and j finish in DECODE; a complete sw ends the run
    opcode = 6'b001111;
    step("lui_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("lui_decode", v(1,1,0,1,0,0,0,1,1,0,0,0,1,0));
    opcode = 6'b000010;
    step("j_fetch",    v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("j_decode",   v(1,1,0,0,0,2,0,0,0,0,0,0,1,0));
    opcode = 6'b101011;
    step("sw2_fetch",  v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("sw2_decode", v(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("sw2_exec",   v(2,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("sw2_mem",    v(3,1,0,0,1,0,0,0,0,0,1,0,1,0));
    step("next_fetch", v(0,0,1,0,0,0,0,0,0,0,0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
